// File: rtl/pc_unit.sv
// Fetch program counter: selects the next PC from reset, trap, redirect, RAS pop, call or PC+4,
// and keeps a circular return-address stack for predicted calls and returns.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic [XLEN-1:0] call_target,
    input  logic            ret,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_miss,
    output logic            misalign
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [PTR_W:0]  CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(4);

    // Instruction addresses are word aligned; low bits of any target are dropped.
    function automatic logic [XLEN-1:0] align_tgt(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[1:0];
    endfunction

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [PTR_W:0]  r_cnt;
    logic            r_miss;
    logic            r_misalign;

    logic [1:0]       w_state_nxt;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [XLEN-1:0]  w_pc_plus4;
    logic [XLEN-1:0]  w_ras_top;
    logic [PTR_W-1:0] w_tos_inc;
    logic [PTR_W-1:0] w_tos_dec;
    logic             w_push;
    logic             w_pop;
    logic             w_miss_nxt;
    logic             w_misalign_nxt;
    logic             w_ras_empty;
    logic             w_ras_full;

    assign w_pc_plus4  = r_pc + PC_INC;
    assign w_ras_empty = (r_cnt == '0);
    assign w_ras_full  = (r_cnt == CNT_MAX);
    assign w_ras_top   = r_ras[r_tos];
    assign w_tos_inc   = r_tos + 1'b1;
    assign w_tos_dec   = r_tos - 1'b1;

    // Next-PC selection: trap and redirect win in every state, the rest only while running.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_miss_nxt     = 1'b0;
        w_misalign_nxt = 1'b0;
        if (trap) begin
            w_state_nxt    = S_RUN;
            w_pc_nxt       = align_tgt(trap_vec);
            w_misalign_nxt = is_misaligned(trap_vec);
        end else if (redirect_valid) begin
            w_state_nxt    = S_RUN;
            w_pc_nxt       = align_tgt(redirect_target);
            w_misalign_nxt = is_misaligned(redirect_target);
        end else begin
            case (r_state)
                S_BOOT: w_state_nxt = S_RUN;
                S_RUN: begin
                    if (halt) begin
                        w_state_nxt = S_HALT;
                    end else if (stall) begin
                        w_pc_nxt = r_pc;
                    end else if (ret) begin
                        if (w_ras_empty) begin
                            w_pc_nxt   = w_pc_plus4;
                            w_miss_nxt = 1'b1;
                        end else begin
                            w_pc_nxt       = align_tgt(w_ras_top);
                            w_misalign_nxt = is_misaligned(w_ras_top);
                            w_pop          = 1'b1;
                        end
                    end else if (call) begin
                        w_pc_nxt       = align_tgt(call_target);
                        w_misalign_nxt = is_misaligned(call_target);
                        w_push         = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
                S_HALT: w_state_nxt = S_HALT;
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_tos      <= '0;
            r_cnt      <= '0;
            r_miss     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_miss     <= w_miss_nxt;
            r_misalign <= w_misalign_nxt;
            // A push onto a full stack overwrites the oldest entry, so the count saturates.
            if (w_push) begin
                r_tos <= w_tos_inc;
                if (!w_ras_full) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_pop) begin
                r_tos <= w_tos_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Stack storage carries data only and is never cleared; the count qualifies it.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_ras[w_tos_inc] <= w_pc_plus4;
        end
    end

    assign pc_out    = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign pc_valid  = (r_state == S_RUN);
    assign ras_empty = w_ras_empty;
    assign ras_full  = w_ras_full;
    assign ras_miss  = r_miss;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps queue the expected post-edge outputs,
// a negedge monitor pops and compares them.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, halt, trap, redirect_valid, call, ret;
    logic [31:0] trap_vec, redirect_target, call_target;
    logic [31:0] pc_out, pc_plus4;
    logic        pc_valid, ras_empty, ras_full, ras_miss, misalign;

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .trap(trap),
        .trap_vec(trap_vec), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .call(call), .call_target(call_target),
        .ret(ret), .pc_out(pc_out), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss),
        .misalign(misalign)
    );

    typedef struct {
        int          stamp;
        string       name;
        logic [36:0] exp;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic [36:0] act;
    int          edges = 0;
    int          total = 0;
    int          bad   = 0;
    bit          done  = 1'b0;

    always @(posedge clk) edges <= edges + 1;

    // Monitor: compares every output bundle whose edge has occurred.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].stamp <= edges) begin
            cur = sbq.pop_front();
            act = {pc_out, pc_valid, ras_empty, ras_full, ras_miss, misalign};
            total++;
            if (act !== cur.exp) begin
                bad++;
                $display("FAIL %s: got pc=%h v=%b empty=%b full=%b miss=%b mis=%b, want pc=%h v=%b empty=%b full=%b miss=%b mis=%b",
                         cur.name, act[36:5], act[4], act[3], act[2], act[1], act[0],
                         cur.exp[36:5], cur.exp[4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
            end
        end
        if (done && sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sbq.size());
            sbq.delete();
        end
    end

    task automatic clear_inputs();
        reset = 0; stall = 0; halt = 0; trap = 0; redirect_valid = 0; call = 0; ret = 0;
        trap_vec = '0; redirect_target = '0; call_target = '0;
    endtask

    // Queue the outputs expected after the coming edge, apply it, then release inputs.
    task automatic tick(input string nm, input logic [31:0] epc,
                        input logic ev, input logic ee, input logic ef,
                        input logic em, input logic ea);
        exp_t e;
        e.stamp = edges + 1;
        e.name  = nm;
        e.exp   = {epc, ev, ee, ef, em, ea};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        tick("reset",       32'h0,   0, 1, 0, 0, 0);
        tick("boot_hold",   32'h0,   1, 1, 0, 0, 0);
        tick("seq_4",       32'h4,   1, 1, 0, 0, 0);
        tick("seq_8",       32'h8,   1, 1, 0, 0, 0);
        tick("seq_c",       32'hC,   1, 1, 0, 0, 0);
        tick("seq_10",      32'h10,  1, 1, 0, 0, 0);
        call = 1; call_target = 32'h200;
        tick("call_200",    32'h200, 1, 0, 0, 0, 0);
        tick("seq_204",     32'h204, 1, 0, 0, 0, 0);
        ret = 1;
        tick("ret_14",      32'h14,  1, 1, 0, 0, 0);
        tick("seq_18",      32'h18,  1, 1, 0, 0, 0);
        tick("seq_1c",      32'h1C,  1, 1, 0, 0, 0);
        tick("seq_20",      32'h20,  1, 1, 0, 0, 0);
        halt = 1;
        tick("halt_enter",  32'h20,  0, 1, 0, 0, 0);
        tick("halt_hold",   32'h20,  0, 1, 0, 0, 0);
        trap = 1; trap_vec = 32'h100;
        tick("trap_100",    32'h100, 1, 1, 0, 0, 0);
        tick("seq_104",     32'h104, 1, 1, 0, 0, 0);
        stall = 1; redirect_valid = 1; redirect_target = 32'h400;
        tick("stall_redir", 32'h400, 1, 1, 0, 0, 0);
        stall = 1;
        tick("stall_1",     32'h400, 1, 1, 0, 0, 0);
        stall = 1; call = 1; call_target = 32'h900;
        tick("stall_call",  32'h400, 1, 1, 0, 0, 0);
        stall = 1;
        tick("stall_3",     32'h400, 1, 1, 0, 0, 0);
        tick("seq_404",     32'h404, 1, 1, 0, 0, 0);
        redirect_valid = 1; redirect_target = 32'h203;
        tick("redir_mis",   32'h200, 1, 1, 0, 0, 1);
        tick("mis_clear",   32'h204, 1, 1, 0, 0, 0);
        call = 1; call_target = 32'h300;
        tick("call_1",      32'h300, 1, 0, 0, 0, 0);
        call = 1; call_target = 32'h400;
        tick("call_2",      32'h400, 1, 0, 0, 0, 0);
        call = 1; call_target = 32'h500;
        tick("call_3",      32'h500, 1, 0, 0, 0, 0);
        call = 1; call_target = 32'h600;
        tick("call_4_full", 32'h600, 1, 0, 1, 0, 0);
        call = 1; call_target = 32'h700;
        tick("call_5_ovw",  32'h700, 1, 0, 1, 0, 0);
        ret = 1;
        tick("ret_604",     32'h604, 1, 0, 0, 0, 0);
        ret = 1;
        tick("ret_504",     32'h504, 1, 0, 0, 0, 0);
        ret = 1;
        tick("ret_404",     32'h404, 1, 0, 0, 0, 0);
        ret = 1;
        tick("ret_304",     32'h304, 1, 1, 0, 0, 0);
        ret = 1;
        tick("ret_miss",    32'h308, 1, 1, 0, 1, 0);
        tick("miss_clear",  32'h30C, 1, 1, 0, 0, 0);
        ret = 1; call = 1; call_target = 32'h800;
        tick("ret_call",    32'h310, 1, 1, 0, 1, 0);
        tick("seq_314",     32'h314, 1, 1, 0, 0, 0);
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick("redir_top",   32'hFFFF_FFFC, 1, 1, 0, 0, 0);
        tick("wrap_0",      32'h0,   1, 1, 0, 0, 0);
        call = 1; call_target = 32'h40;
        tick("call_40",     32'h40,  1, 0, 0, 0, 0);
        reset = 1; redirect_valid = 1; redirect_target = 32'h500;
        tick("reset_mid",   32'h0,   0, 1, 0, 0, 0);
        redirect_valid = 1; redirect_target = 32'h80;
        tick("boot_redir",  32'h80,  1, 1, 0, 0, 0);
        tick("seq_84",      32'h84,  1, 1, 0, 0, 0);
        halt = 1; trap = 1; trap_vec = 32'h120;
        tick("halt_trap",   32'h120, 1, 1, 0, 0, 0);
        tick("seq_124",     32'h124, 1, 1, 0, 0, 0);
        call = 1; call_target = 32'h502;
        tick("call_mis",    32'h500, 1, 0, 0, 0, 1);
        ret = 1;
        tick("ret_128",     32'h128, 1, 1, 0, 0, 0);
        halt = 1;
        tick("halt_2",      32'h128, 0, 1, 0, 0, 0);
        halt = 1; call = 1; call_target = 32'h700;
        tick("halt_call",   32'h128, 0, 1, 0, 0, 0);
        redirect_valid = 1; redirect_target = 32'h600;
        tick("halt_redir",  32'h600, 1, 1, 0, 0, 0);
        tick("seq_604",     32'h604, 1, 1, 0, 0, 0);

        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
